// File: rtl/ondra_mem_pkg.sv
// Shared definitions for the Ondra memory subsystem: arbiter state encoding
// and the default boot-configuration location and SRAM access timing.
package ondra_mem_pkg;

    localparam int          ADDR_W_DFLT   = 19;
    localparam logic [18:0] CFG_ADDR_DFLT = 19'h08FD5;
    localparam int          SETTLE_DFLT   = 2;

    typedef enum logic [2:0] {
        BOOT       = 3'd0,
        BOOT_LATCH = 3'd1,
        IDLE       = 3'd2,
        AUX_SETUP  = 3'd3,
        AUX_ACCESS = 3'd4,
        AUX_DONE   = 3'd5
    } arb_state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the core (absolute priority, never stalled)
// and an auxiliary loader, after fetching the boot configuration byte.
//
// state      | meaning
// BOOT       | address the config byte, wait SETTLE cycles
// BOOT_LATCH | capture config byte, set cfg_valid
// IDLE       | core pass-through, accept aux request when core is off the bus
// AUX_SETUP  | present aux address one cycle with write disabled
// AUX_ACCESS | SETTLE cycles of aux read/write
// AUX_DONE   | write released, address held, aux_ack pulse
module sram_arbiter
    import ondra_mem_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DFLT,
    parameter logic [ADDR_W-1:0] CFG_ADDR = ADDR_W'(CFG_ADDR_DFLT),
    parameter int                SETTLE   = SETTLE_DFLT
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              core_sel,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_we_n,
    input  logic [7:0]        core_wdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [7:0]        aux_wdata,
    output logic              aux_ack,
    output logic [7:0]        aux_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    output logic              sram_we_n,
    output logic              sram_oe,
    input  logic [7:0]        sram_rdata,
    output logic [7:0]        cfg_byte,
    output logic              cfg_valid
);

    localparam logic [2:0] SETTLE_C = 3'(SETTLE);

    arb_state_t        state;
    logic [2:0]        cnt;
    logic              aux_we_q;
    logic [ADDR_W-1:0] pin_addr;
    logic [7:0]        pin_wdata;
    logic              pin_we_n;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            cnt       <= SETTLE_C;
            aux_we_q  <= 1'b0;
            aux_ack   <= 1'b0;
            aux_rdata <= 8'h00;
            cfg_byte  <= 8'h00;
            cfg_valid <= 1'b0;
        end else begin
            aux_ack <= 1'b0;
            case (state)
                BOOT: begin
                    if (cnt == 3'd1) begin
                        cnt   <= SETTLE_C;
                        state <= BOOT_LATCH;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                BOOT_LATCH: begin
                    cfg_byte  <= sram_rdata;
                    cfg_valid <= 1'b1;
                    state     <= IDLE;
                end
                IDLE: begin
                    if (aux_req && !core_sel) begin
                        aux_we_q <= aux_we;
                        state    <= AUX_SETUP;
                    end
                end
                AUX_SETUP: begin
                    if (core_sel || !aux_req) state <= IDLE;
                    else                      state <= AUX_ACCESS;
                end
                AUX_ACCESS: begin
                    // Core grabbing the bus or the requester giving up drops the
                    // access; a still-pending request is re-sampled from IDLE.
                    if (core_sel || !aux_req) begin
                        cnt   <= SETTLE_C;
                        state <= IDLE;
                    end else if (cnt == 3'd1) begin
                        cnt     <= SETTLE_C;
                        aux_ack <= 1'b1;
                        state   <= AUX_DONE;
                        if (!aux_we_q) aux_rdata <= sram_rdata;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                AUX_DONE: state <= IDLE;
                default:  state <= BOOT;
            endcase
        end
    end

    always_comb begin
        pin_addr  = '0;
        pin_wdata = 8'h00;
        pin_we_n  = 1'b1;
        if (state == BOOT || state == BOOT_LATCH) begin
            pin_addr = CFG_ADDR;
        end else if (core_sel) begin
            pin_addr  = core_addr;
            pin_wdata = core_wdata;
            pin_we_n  = core_we_n;
        end else begin
            case (state)
                AUX_SETUP, AUX_DONE: begin
                    pin_addr  = aux_addr;
                    pin_wdata = aux_wdata;
                end
                AUX_ACCESS: begin
                    pin_addr  = aux_addr;
                    pin_wdata = aux_wdata;
                    pin_we_n  = ~aux_we_q;
                end
                default: ;
            endcase
        end
    end

    // Reset gates the write strobe directly so an interrupted write ends at once.
    assign sram_addr  = pin_addr;
    assign sram_wdata = pin_wdata;
    assign sram_we_n  = pin_we_n | reset;
    assign sram_oe    = ~sram_we_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: boot fetch, aux read/write, core preemption,
// back-to-back, abandon and mid-write reset, against a behavioural SRAM.
module tb_sram_arbiter;

    localparam int AW = 19;
    localparam logic [31:0] CFG = 32'h08FD5;

    logic          clk_sys    = 1'b0;
    logic          reset      = 1'b1;
    logic          core_sel   = 1'b0;
    logic [AW-1:0] core_addr  = '0;
    logic          core_we_n  = 1'b1;
    logic [7:0]    core_wdata = 8'h00;
    logic          aux_req    = 1'b0;
    logic          aux_we     = 1'b0;
    logic [AW-1:0] aux_addr   = '0;
    logic [7:0]    aux_wdata  = 8'h00;
    logic          aux_ack;
    logic [7:0]    aux_rdata;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_wdata;
    logic          sram_we_n;
    logic          sram_oe;
    logic [7:0]    sram_rdata;
    logic [7:0]    cfg_byte;
    logic          cfg_valid;

    logic [7:0] mem [0:(1<<AW)-1];
    int n_tests = 0;
    int n_fail  = 0;

    sram_arbiter dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .core_sel   (core_sel),
        .core_addr  (core_addr),
        .core_we_n  (core_we_n),
        .core_wdata (core_wdata),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_ack    (aux_ack),
        .aux_rdata  (aux_rdata),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we_n  (sram_we_n),
        .sram_oe    (sram_oe),
        .sram_rdata (sram_rdata),
        .cfg_byte   (cfg_byte),
        .cfg_valid  (cfg_valid)
    );

    always #5 clk_sys = ~clk_sys;

    assign sram_rdata = mem[sram_addr];
    always @(posedge clk_sys) if (!sram_we_n) mem[sram_addr] <= sram_wdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!aux_ack && lat < 20);
    endtask

    task automatic boot_check(input string tag, output int acks);
        acks = 0;
        for (int c = 1; c <= 3; c++) begin
            chk({tag, "_addr"}, 32'(sram_addr), CFG);
            chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
            chk({tag, "_valid_lo"}, 32'(cfg_valid), 32'd0);
            tick();
            if (aux_ack) acks++;
        end
        chk({tag, "_valid"}, 32'(cfg_valid), 32'd1);
        chk({tag, "_byte"}, 32'(cfg_byte), 32'h0000_00A5);
    endtask

    initial begin
        int lat;
        int acks;
        int lo;

        mem[19'h08FD5] = 8'hA5;
        mem[19'h01234] = 8'h3C;

        // core tries to write during reset and boot; must be ignored
        core_sel = 1'b1; core_we_n = 1'b0; core_addr = 19'h7FFFF; core_wdata = 8'hEE;
        repeat (3) tick();
        chk("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        chk("rst_cfg_byte", 32'(cfg_byte), 32'd0);
        chk("rst_ack", 32'(aux_ack), 32'd0);
        chk("rst_rdata", 32'(aux_rdata), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_oe), 32'd0);

        reset = 1'b0;
        #1;
        boot_check("boot", acks);

        // cycle 4: core owns the pins
        chk("core_addr", 32'(sram_addr), 32'h7FFFF);
        chk("core_we_n", 32'(sram_we_n), 32'd0);
        chk("core_oe", 32'(sram_oe), 32'd1);
        chk("core_wdata", 32'(sram_wdata), 32'h0000_00EE);
        core_sel = 1'b0; core_we_n = 1'b1;
        #1;
        chk("idle_addr", 32'(sram_addr), 32'd0);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("idle_oe", 32'(sram_oe), 32'd0);

        // aux read
        aux_we = 1'b0; aux_addr = 19'h01234; aux_req = 1'b1;
        wait_ack(lat);
        chk("rd_lat", 32'(lat), 32'd4);
        chk("rd_data", 32'(aux_rdata), 32'h0000_003C);
        aux_req = 1'b0;
        tick();
        chk("rd_single_pulse", 32'(aux_ack), 32'd0);

        // aux write with pin timing
        aux_we = 1'b1; aux_addr = 19'h00010; aux_wdata = 8'h5A; aux_req = 1'b1;
        lo = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (!sram_we_n) lo++;
            if (k == 1) begin
                chk("wr_setup_addr", 32'(sram_addr), 32'h10);
                chk("wr_setup_we_n", 32'(sram_we_n), 32'd1);
            end
            if (k == 2) chk("wr_access_wdata", 32'(sram_wdata), 32'h5A);
            if (k == 4) begin
                chk("wr_done_addr", 32'(sram_addr), 32'h10);
                chk("wr_done_we_n", 32'(sram_we_n), 32'd1);
                chk("wr_done_ack", 32'(aux_ack), 32'd1);
            end
        end
        chk("wr_low_cycles", 32'(lo), 32'd2);
        aux_req = 1'b0;
        tick();
        aux_we = 1'b0; aux_req = 1'b1;
        wait_ack(lat);
        chk("wr_readback_lat", 32'(lat), 32'd4);
        chk("wr_readback", 32'(aux_rdata), 32'h5A);
        aux_req = 1'b0;
        tick();

        // core preempts on 2nd access cycle of an aux write
        aux_we = 1'b1; aux_addr = 19'h00020; aux_wdata = 8'h77; aux_req = 1'b1;
        repeat (3) tick();
        core_sel = 1'b1; core_we_n = 1'b1; core_addr = 19'h00300;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_addr", 32'(sram_addr), 32'h300);
        chk("abort_ack", 32'(aux_ack), 32'd0);
        tick();
        chk("abort_no_ack", 32'(aux_ack), 32'd0);
        core_sel = 1'b0;
        wait_ack(lat);
        chk("abort_restart_lat", 32'(lat), 32'd4);
        aux_req = 1'b0;
        tick();
        aux_we = 1'b0; aux_req = 1'b1;
        wait_ack(lat);
        chk("abort_readback", 32'(aux_rdata), 32'h77);
        aux_req = 1'b0;
        tick();

        // back-to-back reads
        aux_we = 1'b0; aux_addr = 19'h01234; aux_req = 1'b1;
        wait_ack(lat);
        chk("b2b_first_lat", 32'(lat), 32'd4);
        wait_ack(lat);
        chk("b2b_gap", 32'(lat), 32'd5);
        aux_req = 1'b0;
        tick();

        // core arrives during AUX_DONE: ack still issued
        aux_req = 1'b1;
        repeat (4) tick();
        core_sel = 1'b1; core_addr = 19'h00555; core_we_n = 1'b1;
        #1;
        chk("done_core_ack", 32'(aux_ack), 32'd1);
        chk("done_core_rdata", 32'(aux_rdata), 32'h3C);
        chk("done_core_addr", 32'(sram_addr), 32'h555);
        aux_req = 1'b0;
        tick();
        core_sel = 1'b0;

        // request withdrawn mid-access
        aux_we = 1'b1; aux_addr = 19'h00030; aux_wdata = 8'h99; aux_req = 1'b1;
        repeat (2) tick();
        aux_req = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (aux_ack) acks++;
        end
        chk("drop_no_ack", 32'(acks), 32'd0);

        // reset in the middle of an aux write
        aux_we = 1'b1; aux_addr = 19'h00040; aux_wdata = 8'h11; aux_req = 1'b1;
        repeat (2) tick();
        chk("rw_pre_we_n", 32'(sram_we_n), 32'd0);
        reset = 1'b1;
        #1;
        chk("rw_we_n", 32'(sram_we_n), 32'd1);
        chk("rw_cfg_valid", 32'(cfg_valid), 32'd0);
        chk("rw_ack", 32'(aux_ack), 32'd0);
        chk("rw_rdata", 32'(aux_rdata), 32'd0);
        aux_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        boot_check("reboot", acks);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (aux_ack) acks++;
        end
        chk("reboot_no_stale_ack", 32'(acks), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
